// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory req/ack bus between the fetch stage and imem
interface if_stage_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: PC, imem req/ack fetch FSM, IF/ID register with one-entry skid buffer; IF_PERF_CNT_EN adds fetch/bubble counters
module if_stage #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter logic [15:0]       BUBBLE_INSTR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    if_stage_if.master        imem,
    output logic              ifid_valid,
    output logic [15:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc1,
    output logic [3:0]        OpCode,
    output logic [2:0]        Cond
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       bubble_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [15:0]       ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc1_q, ifid_pc1_d;
    logic [15:0]       skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc1_q, skid_pc1_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              req;

    assign pc_inc         = pc_q + ADDR_W'(1);
    assign req            = (state_q == FETCH) || (state_q == DROP);
    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_instr     = ifid_valid_q ? ifid_instr_q : BUBBLE_INSTR;
    assign ifid_pc1       = ifid_pc1_q;
    assign OpCode         = ifid_instr[15:12];
    assign Cond           = ifid_instr[11:9];

    // Next-state logic: a redirect overrides stall and ack; the skid is only live in HOLD
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc1_d   = ifid_pc1_q;
        skid_instr_d = skid_instr_q;
        skid_pc1_d   = skid_pc1_q;
        if (br_taken) begin
            pc_d         = br_target;
            ifid_valid_d = 1'b0;
            state_d      = (req && !imem.imem_ack) ? DROP : FETCH;
            drop_addr_d  = (state_q == FETCH) ? pc_q : drop_addr_q;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem.imem_ack) begin
                        pc_d = pc_inc;
                        if (!stall || !ifid_valid_q) begin
                            ifid_valid_d = 1'b1;
                            ifid_instr_d = imem.imem_rdata;
                            ifid_pc1_d   = pc_inc;
                        end else begin
                            skid_instr_d = imem.imem_rdata;
                            skid_pc1_d   = pc_inc;
                            state_d      = HOLD;
                        end
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                    end
                end
                DROP: state_d = imem.imem_ack ? FETCH : DROP;
                HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = skid_instr_q;
                        ifid_pc1_d   = skid_pc1_q;
                        state_d      = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Fetch state, PC and pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE_INSTR;
            ifid_pc1_q   <= '0;
            skid_instr_q <= BUBBLE_INSTR;
            skid_pc1_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc1_q   <= ifid_pc1_d;
            skid_instr_q <= skid_instr_d;
            skid_pc1_q   <= skid_pc1_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Saturating counts of accepted fetches and bubble cycles
    always_comb begin
        fetch_cnt_d  = (state_q == FETCH && imem.imem_ack && !br_taken && fetch_cnt_q != 16'hFFFF)
                       ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
        bubble_cnt_d = (!ifid_valid_q && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage (perf counter checks under IF_PERF_CNT_EN)
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc1;
    logic [3:0]  OpCode;
    logic [2:0]  Cond;
    int          checks = 0;
    int          failures = 0;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt, bubble_cnt;
`endif

    if_stage_if #(.ADDR_W(16)) bus ();

    if_stage #(.ADDR_W(16), .RESET_PC(16'h0000), .BUBBLE_INSTR(16'h0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem(bus.master), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
        .ifid_pc1(ifid_pc1), .OpCode(OpCode), .Cond(Cond)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        step(); step();
        if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end checks++;
        if (ifid_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end checks++;
        if (ifid_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", ifid_instr); end checks++;
        if (ifid_pc1 !== 16'h0000) begin failures++; $display("FAIL reset_pc1 got=%h exp=0000", ifid_pc1); end checks++;
        rst = 1'b0;
        step();
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin failures++; $display("FAIL first_fetch got req=%b addr=%h exp req=1 addr=0000", bus.imem_req, bus.imem_addr); end checks++;
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = {4'(i), 12'h123};
            if (bus.imem_addr !== 16'(i)) begin failures++; $display("FAIL zw_addr%0d got=%h exp=%h", i, bus.imem_addr, 16'(i)); end checks++;
            step();
            if (OpCode !== 4'(i) || ifid_pc1 !== 16'(i + 1) || ifid_valid !== 1'b1) begin
                failures++; $display("FAIL zw_out%0d got op=%h pc1=%h v=%b exp op=%h pc1=%h v=1", i, OpCode, ifid_pc1, ifid_valid, 4'(i), 16'(i + 1));
            end checks++;
        end
        bus.imem_ack = 1'b0;
`ifdef IF_PERF_CNT_EN
        if (fetch_cnt !== 16'd4 || bubble_cnt !== 16'd2) begin failures++; $display("FAIL perf_cnt got f=%0d b=%0d exp f=4 b=2", fetch_cnt, bubble_cnt); end checks++;
`endif
    endtask

    task automatic test_wait_states();
        do_reset();
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.imem_addr !== 16'h0000 || ifid_valid !== 1'b0) begin failures++; $display("FAIL ws_wait%0d got addr=%h v=%b exp addr=0000 v=0", i, bus.imem_addr, ifid_valid); end checks++;
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hC600;
        step();
        bus.imem_ack = 1'b0;
        if (OpCode !== 4'hC || Cond !== 3'b011 || ifid_pc1 !== 16'h0001) begin failures++; $display("FAIL ws_out got op=%h cond=%b pc1=%h exp op=c cond=011 pc1=0001", OpCode, Cond, ifid_pc1); end checks++;
        if (bus.imem_addr !== 16'h0001) begin failures++; $display("FAIL ws_next_addr got=%h exp=0001", bus.imem_addr); end checks++;
    endtask

    task automatic test_stall_skid();
        do_reset();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2000;
        step();
        stall = 1'b1; bus.imem_ack = 1'b0;
        step();
        if (ifid_instr !== 16'h2000 || ifid_valid !== 1'b1 || bus.imem_addr !== 16'h0001) begin failures++; $display("FAIL stall_noack got instr=%h v=%b addr=%h exp 2000 1 0001", ifid_instr, ifid_valid, bus.imem_addr); end checks++;
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h8123;
        step();
        bus.imem_ack = 1'b0;
        if (bus.imem_req !== 1'b0 || ifid_instr !== 16'h2000 || ifid_pc1 !== 16'h0001) begin failures++; $display("FAIL hold_enter got req=%b instr=%h pc1=%h exp 0 2000 0001", bus.imem_req, ifid_instr, ifid_pc1); end checks++;
        step();
        if (bus.imem_req !== 1'b0 || ifid_instr !== 16'h2000) begin failures++; $display("FAIL hold_stay got req=%b instr=%h exp 0 2000", bus.imem_req, ifid_instr); end checks++;
        stall = 1'b0;
        step();
        if (ifid_instr !== 16'h8123 || ifid_pc1 !== 16'h0002 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin
            failures++; $display("FAIL skid_release got instr=%h pc1=%h req=%b addr=%h exp 8123 0002 1 0002", ifid_instr, ifid_pc1, bus.imem_req, bus.imem_addr);
        end checks++;
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h3000;
        step();
        bus.imem_ack = 1'b0;
        if (ifid_instr !== 16'h3000 || ifid_pc1 !== 16'h0003) begin failures++; $display("FAIL after_skid got instr=%h pc1=%h exp 3000 0003", ifid_instr, ifid_pc1); end checks++;
    endtask

    task automatic test_redirect_drop();
        do_reset();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1000;
        repeat (5) step();
        bus.imem_ack = 1'b0;
        step();
        if (bus.imem_addr !== 16'h0005) begin failures++; $display("FAIL drop_pre_addr got=%h exp=0005", bus.imem_addr); end checks++;
        br_taken = 1'b1; br_target = 16'h0040;
        step();
        br_taken = 1'b0;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0005 || ifid_valid !== 1'b0) begin failures++; $display("FAIL drop_state got req=%b addr=%h v=%b exp 1 0005 0", bus.imem_req, bus.imem_addr, ifid_valid); end checks++;
        step();
        if (bus.imem_addr !== 16'h0005 || ifid_valid !== 1'b0) begin failures++; $display("FAIL drop_wait got addr=%h v=%b exp 0005 0", bus.imem_addr, ifid_valid); end checks++;
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF;
        step();
        if (bus.imem_addr !== 16'h0040 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000) begin failures++; $display("FAIL drop_discard got addr=%h v=%b instr=%h exp 0040 0 0000", bus.imem_addr, ifid_valid, ifid_instr); end checks++;
        bus.imem_rdata = 16'h5000;
        step();
        bus.imem_ack = 1'b0;
        if (ifid_instr !== 16'h5000 || ifid_pc1 !== 16'h0041) begin failures++; $display("FAIL drop_resume got instr=%h pc1=%h exp 5000 0041", ifid_instr, ifid_pc1); end checks++;
    endtask

    task automatic test_branch_priority();
        do_reset();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2000;
        step();
        stall = 1'b1; bus.imem_rdata = 16'h7777; br_taken = 1'b1; br_target = 16'h0100;
        step();
        br_taken = 1'b0; stall = 1'b0;
        if (ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin
            failures++; $display("FAIL br_prio got v=%b instr=%h req=%b addr=%h exp 0 0000 1 0100", ifid_valid, ifid_instr, bus.imem_req, bus.imem_addr);
        end checks++;
        bus.imem_rdata = 16'h6000;
        step();
        bus.imem_ack = 1'b0;
        if (ifid_instr !== 16'h6000 || ifid_pc1 !== 16'h0101) begin failures++; $display("FAIL br_resume got instr=%h pc1=%h exp 6000 0101", ifid_instr, ifid_pc1); end checks++;
    endtask

    task automatic test_wrap();
        do_reset();
        br_taken = 1'b1; br_target = 16'hFFFF;
        step();
        br_taken = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
        step();
        if (bus.imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ffff", bus.imem_addr); end checks++;
        bus.imem_rdata = 16'h9E00;
        step();
        bus.imem_ack = 1'b0;
        if (ifid_pc1 !== 16'h0000 || OpCode !== 4'h9 || Cond !== 3'b111 || bus.imem_addr !== 16'h0000) begin
            failures++; $display("FAIL wrap_out got pc1=%h op=%h cond=%b addr=%h exp 0000 9 111 0000", ifid_pc1, OpCode, Cond, bus.imem_addr);
        end checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.imem_ack = 1'b1; bus.imem_rdata = 16'h4321;
        step();
        bus.imem_ack = 1'b0;
        step();
        rst = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hABCD;
        step();
        if (bus.imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 16'h0000 || ifid_pc1 !== 16'h0000) begin
            failures++; $display("FAIL rst_mid got req=%b v=%b instr=%h pc1=%h exp 0 0 0000 0000", bus.imem_req, ifid_valid, ifid_instr, ifid_pc1);
        end checks++;
        rst = 1'b0;
        step();
        bus.imem_ack = 1'b0;
        if (bus.imem_addr !== 16'h0000 || ifid_valid !== 1'b0 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL rst_stray_ack got addr=%h v=%b req=%b exp 0000 0 1", bus.imem_addr, ifid_valid, bus.imem_req); end checks++;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_skid();
        test_redirect_drop();
        test_branch_priority();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
